// File: rtl/ntt_bfu_if.sv
// Sample handshake and result bus of the NTT butterfly unit.
interface ntt_bfu_if #(
   parameter int W = 12
);
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_w;
   logic         out_valid;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic         busy;

   modport master (
      output in_valid, in_mode, in_a, in_b, in_w,
      input  in_ready, out_valid, out_a, out_b, busy
   );

   modport slave (
      input  in_valid, in_mode, in_a, in_b, in_w,
      output in_ready, out_valid, out_a, out_b, busy
   );
endinterface

// File: rtl/ntt_bfu.sv
// Pipelined CT/GS butterfly for NTT over Z_Q with an embedded
// Montgomery multiplier (R = 2^DATA_WIDTH).
package ntt_pkg;
   localparam int DATA_WIDTH = 12;
   localparam int Q          = 3329;
   localparam int MO_MUL_LAT = 2;
   // -Q^-1 mod 2^DATA_WIDTH
   localparam int Q_NEG_INV  = 3327;
endpackage

module mo_mul
   import ntt_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int LAT   = MO_MUL_LAT
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r
);
   localparam int PW = 2 * WIDTH + 1;
   localparam logic [WIDTH-1:0] MQ = WIDTH'(Q);
   localparam logic [WIDTH-1:0] QP = WIDTH'(Q_NEG_INV);

   logic [2*WIDTH-1:0] t;
   logic [WIDTH-1:0]   m;
   logic [PW-1:0]      s;
   logic [WIDTH:0]     u;
   logic [WIDTH-1:0]   pipe_d [LAT];
   logic [WIDTH-1:0]   pipe_q [LAT];

   // REDC: u = (t + m*Q) / R lands in [0, 2Q) for a, b < Q
   always_comb begin
      t = {WIDTH'(0), a} * {WIDTH'(0), b};
      m = WIDTH'(t[WIDTH-1:0] * QP);
      s = PW'(t) + PW'({WIDTH'(0), m} * {WIDTH'(0), MQ});
      u = (WIDTH + 1)'(s >> WIDTH);
      pipe_d[0] = (u >= {1'b0, MQ}) ? WIDTH'(u - {1'b0, MQ})
                                    : u[WIDTH-1:0];
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
   end

   assign r = pipe_q[LAT-1];
endmodule

module ntt_bfu
   import ntt_pkg::*;
#(
   parameter int MUL_LAT = MO_MUL_LAT
) (
   input logic      clk,
   input logic      rst,
   ntt_bfu_if.slave io
);
   localparam int L  = MUL_LAT + 2;
   localparam int CW = $clog2(L + 1);
   localparam int DW = DATA_WIDTH;
   localparam logic [DW:0]   QW = (DW + 1)'(Q);
   localparam logic [DW-1:0] QN = DW'(Q);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic logic [DW-1:0] add_mod(
      input logic [DW-1:0] x,
      input logic [DW-1:0] y
   );
      logic [DW:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= QW) s = s - QW;
      return s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] sub_mod(
      input logic [DW-1:0] x,
      input logic [DW-1:0] y
   );
      logic [DW:0] d;
      d = {1'b0, x} - {1'b0, y};
      if (d[DW]) d = d + QW;
      return d[DW-1:0];
   endfunction

   state_t          state_q;
   logic            mode_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ready, xfer;

   logic            v1_q, v1_d, m1_q, m1_d;
   logic [DW-1:0]   x1_q, x1_d, y1_q, y1_d, w1_q, w1_d;
   logic            vd_q [MUL_LAT];
   logic            vd_d [MUL_LAT];
   logic            md_q [MUL_LAT];
   logic            md_d [MUL_LAT];
   logic [DW-1:0]   xd_q [MUL_LAT];
   logic [DW-1:0]   xd_d [MUL_LAT];
   logic [DW-1:0]   mul_r, p;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;

   always_comb begin
      ready = 1'b0;
      unique case (state_q)
         IDLE:    ready = 1'b1;
         RUN:     ready = (io.in_mode == mode_q);
         default: ready = 1'b0;
      endcase
   end

   assign xfer = io.in_valid && ready;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({xfer, out_valid_q})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  state_q <= RUN;
                  mode_q  <= io.in_mode;
               end
            end
            RUN: begin
               if (cnt_d == '0) begin
                  state_q <= IDLE;
               end else if (io.in_valid && (io.in_mode != mode_q)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_q == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // CT passes a/b straight to the multiplier; GS does add/sub first
   always_comb begin
      v1_d = xfer;
      m1_d = io.in_mode;
      w1_d = io.in_w;
      if (io.in_mode) begin
         x1_d = add_mod(io.in_a, io.in_b);
         y1_d = sub_mod(io.in_a, io.in_b);
      end else begin
         x1_d = io.in_a;
         y1_d = io.in_b;
      end
   end

   always_comb begin
      vd_d[0] = v1_q;
      md_d[0] = m1_q;
      xd_d[0] = x1_q;
      for (int i = 1; i < MUL_LAT; i++) begin
         vd_d[i] = vd_q[i-1];
         md_d[i] = md_q[i-1];
         xd_d[i] = xd_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         m1_q <= m1_d;
         x1_q <= x1_d;
         y1_q <= y1_d;
         w1_q <= w1_d;
      end
      md_q <= md_d;
      xd_q <= xd_d;
   end

   mo_mul #(
      .WIDTH (DW),
      .LAT   (MUL_LAT)
   ) u_mul (
      .clk (clk),
      .a   (y1_q),
      .b   (w1_q),
      .r   (mul_r)
   );

   always_comb begin
      p           = (mul_r == QN) ? '0 : mul_r;
      out_valid_d = vd_q[MUL_LAT-1];
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      if (vd_q[MUL_LAT-1]) begin
         if (md_q[MUL_LAT-1]) begin
            out_a_d = xd_q[MUL_LAT-1];
            out_b_d = p;
         end else begin
            out_a_d = add_mod(xd_q[MUL_LAT-1], p);
            out_b_d = sub_mod(xd_q[MUL_LAT-1], p);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         v1_q        <= 1'b0;
         vd_q        <= '{default: 1'b0};
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
      end else begin
         cnt_q       <= cnt_d;
         v1_q        <= v1_d;
         vd_q        <= vd_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
      end
   end

   assign io.in_ready  = ready;
   assign io.out_valid = out_valid_q;
   assign io.out_a     = out_a_q;
   assign io.out_b     = out_b_q;
   assign io.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_ntt_bfu.sv
// Randomized + directed bench for ntt_bfu against a modular-arithmetic
// scoreboard model.
module tb_ntt_bfu;
   import ntt_pkg::*;

   localparam int LAT = MO_MUL_LAT;
   localparam int L   = LAT + 2;

   typedef struct {
      int acc;
      int due;
      int ea;
      int eb;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ntt_bfu_if #(.W(DATA_WIDTH)) bus ();

   ntt_bfu #(.MUL_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rinv     = 0;
   int   ov_count = 0;
   int   run_len  = 0;
   int   max_run  = 0;
   exp_t q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain modular arithmetic: mul(x,w) = x * w * R^-1 mod Q
   function automatic int mulm(input int x, input int w);
      return ((x * w) % Q) * rinv % Q;
   endfunction

   function automatic void model(input bit m, input int a, input int b,
                                 input int w, output int ea, output int eb);
      int pr;
      if (!m) begin
         pr = mulm(b, w);
         ea = (a + pr) % Q;
         eb = (a - pr + Q) % Q;
      end else begin
         ea = (a + b) % Q;
         eb = mulm((a - b + Q) % Q, w);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      bit   be;
      int   ea, eb;
      if (rst) begin
         q.delete();
         run_len = 0;
      end else begin
         be = 1'b0;
         foreach (q[i]) if (q[i].acc < cyc) be = 1'b1;
         chk("busy", int'(bus.busy), int'(be));
         if (bus.out_valid) begin
            ov_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", int'(bus.out_valid), 1);
            chk("out_a", int'(bus.out_a), e.ea);
            chk("out_b", int'(bus.out_b), e.eb);
         end else begin
            chk("out_valid_quiet", int'(bus.out_valid), 0);
         end
         if (bus.in_valid && bus.in_ready) begin
            model(bus.in_mode, int'(bus.in_a), int'(bus.in_b),
                  int'(bus.in_w), ea, eb);
            q.push_back('{cyc, cyc + L, ea, eb});
         end
      end
   end

   task automatic drive(input bit m, input int a, input int b,
                        input int w, output int tries);
      bit r;
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_a     = DATA_WIDTH'(a);
      bus.in_b     = DATA_WIDTH'(b);
      bus.in_w     = DATA_WIDTH'(w);
      tries = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         r = bus.in_ready;
         @(posedge clk);
         #1;
         tries++;
         if (r) return;
      end
      chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         bus.in_mode = 1'($urandom_range(0, 1));
         bus.in_a    = DATA_WIDTH'($urandom_range(0, 4095));
         bus.in_b    = DATA_WIDTH'($urandom_range(0, 4095));
         bus.in_w    = DATA_WIDTH'($urandom_range(0, 4095));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_out(input string nm, input int ea, input int eb);
      int k;
      for (k = 1; k <= 4 * L; k++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      chk({nm, "_latency"}, k, L);
      chk({nm, "_a"}, int'(bus.out_a), ea);
      chk({nm, "_b"}, int'(bus.out_b), eb);
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string nm, input bit m, input int a,
                         input int b, input int w, input int ea, input int eb);
      int t;
      drive(m, a, b, w, t);
      bus.in_valid = 1'b0;
      wait_out(nm, ea, eb);
   endtask

   function automatic int pick();
      int s;
      s = int'($urandom_range(0, 7));
      if (s == 0) return Q - 1;
      if (s == 1) return 0;
      return int'($urandom_range(0, Q - 1));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int ea, eb, t, ov0, first_idle, acc_k;
      bit r, b, mode;

      for (int i = 1; i < Q; i++) begin
         if (((1 << DATA_WIDTH) * i) % Q == 1) rinv = i;
      end

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_mode  = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_w     = '0;

      model(1'b0, 100, 200, 767, ea, eb);
      chk("model_ct1_a", ea, 300);
      chk("model_ct1_b", eb, 3229);
      model(1'b0, 3000, 3000, 767, ea, eb);
      chk("model_ct2_a", ea, 2671);
      chk("model_ct2_b", eb, 0);
      model(1'b1, 100, 200, 767, ea, eb);
      chk("model_gs_a", ea, 300);
      chk("model_gs_b", eb, 3229);

      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_a", int'(bus.out_a), 0);
      chk("rst_out_b", int'(bus.out_b), 0);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      single("ct_100_200", 1'b0, 100, 200, 767, 300, 3229);
      single("ct_3000", 1'b0, 3000, 3000, 767, 2671, 0);
      single("ct_zero", 1'b0, 0, 0, 767, 0, 0);
      single("gs_100_200", 1'b1, 100, 200, 767, 300, 3229);
      idle(2);

      // back-to-back burst of 2L forward butterflies
      ov0     = ov_count;
      max_run = 0;
      for (int i = 0; i < 2 * L; i++) begin
         drive(1'b0, pick(), pick(), pick(), t);
         chk("burst_ready", t, 1);
      end
      idle(3 * L);
      chk("burst_count", ov_count - ov0, 2 * L);
      chk("burst_run", max_run, 2 * L);

      // CT burst then a GS sample while busy
      for (int i = 0; i < 5; i++) drive(1'b0, pick(), pick(), pick(), t);
      bus.in_valid = 1'b1;
      bus.in_mode  = 1'b1;
      bus.in_a     = DATA_WIDTH'(100);
      bus.in_b     = DATA_WIDTH'(200);
      bus.in_w     = DATA_WIDTH'(767);
      first_idle   = -1;
      acc_k        = -100;
      for (int k = 0; k < 3 * L + 10; k++) begin
         @(negedge clk);
         r = bus.in_ready;
         b = bus.busy;
         if (b) chk("drain_ready", int'(r), 0);
         else if (first_idle < 0) first_idle = k;
         if (r) begin
            acc_k = k;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            break;
         end
      end
      chk("drain_accept", acc_k, first_idle + 1);
      wait_out("gs_drain", 300, 3229);
      idle(2);

      // reset with three samples in flight
      for (int i = 0; i < 3; i++) drive(1'b0, 100 + i, 200, 767, t);
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", int'(bus.out_valid), 0);
      chk("mid_rst_out_a", int'(bus.out_a), 0);
      chk("mid_rst_out_b", int'(bus.out_b), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ov0 = ov_count;
      idle(2 * L);
      chk("post_rst_no_out", ov_count - ov0, 0);
      single("post_rst_ct", 1'b0, 100, 200, 767, 300, 3229);

      // randomized traffic with mode switches and gaps
      mode = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         drive(mode, pick(), pick(), pick(), t);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(3 * L);
      chk("final_queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ntt_bfu.md
NTT_BFU -- requirements
Module: ntt_bfu

Interface
REQ-001 Parameter: MUL_LAT, default ntt_pkg MO_MUL_LAT, cycle latency of the embedded mo_mul; the block SHALL be correct for any MUL_LAT >= 1.
REQ-002 Constants: DATA_WIDTH, Q SHALL come from ntt_pkg; no local redefinition.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  input sample present.
REQ-006 in_ready  out  1  block accepts sample this cycle; transfer = in_valid && in_ready.
REQ-007 in_mode  in  1  0 = Cooley-Tukey (forward NTT), 1 = Gentleman-Sande (inverse NTT).
REQ-008 in_a, in_b  in  DATA_WIDTH  butterfly operands, range 0..Q-1.
REQ-009 in_w  in  DATA_WIDTH  twiddle in Montgomery form (w*2^DATA_WIDTH mod Q), range 0..Q-1.
REQ-010 out_valid  out  1  single-cycle pulse per accepted sample; no output backpressure.
REQ-011 out_a, out_b  out  DATA_WIDTH  butterfly results, range 0..Q-1.
REQ-012 busy  out  1  high while any accepted sample has not yet produced out_valid.

Function
REQ-013 One mo_mul instance (WIDTH=DATA_WIDTH) SHALL be embedded; mul(x,w) denotes its result normalized so that a value equal to Q becomes 0.
REQ-014 CT: out_a = (a + mul(b,w)) mod Q, out_b = (a - mul(b,w)) mod Q.
REQ-015 GS: out_a = (a + b) mod Q, out_b = mul((a - b) mod Q, w).
REQ-016 Modular add SHALL use a DATA_WIDTH+1 bit sum, subtracting Q when sum >= Q; modular sub SHALL add Q when the DATA_WIDTH+1 bit difference is negative.
REQ-017 Latency L = MUL_LAT + 2 cycles from the accepting edge to the edge that raises out_valid, identical in both modes.
REQ-018 CT pipeline: input register (1), mo_mul (MUL_LAT), add/sub register (1); in_a SHALL be delayed by a matching shift register.
REQ-019 GS pipeline: add/sub register (1), mo_mul (MUL_LAT), output register (1); the sum SHALL be delayed to align with the product.
REQ-020 Throughput: one sample per cycle while the mode is unchanged; a valid bit SHALL travel with every sample through L stages.
REQ-021 FSM states IDLE, RUN, DRAIN; cur_mode register holds the mode of the in-flight samples.
REQ-022 IDLE: in_ready=1; on transfer, latch cur_mode=in_mode and go RUN.
REQ-023 RUN: in_ready = (in_mode == cur_mode); in_valid with in_mode != cur_mode -> DRAIN, sample not accepted.
REQ-024 RUN -> IDLE when the in-flight counter would reach 0 and no transfer occurs that cycle.
REQ-025 DRAIN: in_ready=0; -> IDLE when counter = 0; the held sample is accepted at the earliest in the cycle after entering IDLE.
REQ-026 In-flight counter range 0..L: +1 on transfer, -1 on out_valid, unchanged when both occur in the same cycle; busy = (counter != 0).
REQ-027 Input data with in_valid=0 SHALL NOT affect any output or counter.

Reset
REQ-028 rst SHALL force state=IDLE, cur_mode=0, counter=0, all pipeline valid bits=0, out_valid=0, out_a=0, out_b=0, busy=0 immediately, independent of clk.
REQ-029 Reset mid-operation SHALL discard all in-flight samples; no out_valid until L cycles after the first post-reset transfer.
REQ-030 Datapath registers inside mo_mul need no reset; only valid bits gate outputs.

Verification (Q=3329, DATA_WIDTH=12, w=767 = Montgomery 1)
REQ-031 CT a=100, b=200, w=767 -> after L cycles out_a=300, out_b=3229, out_valid one cycle.
REQ-032 CT a=3000, b=3000, w=767 -> out_a=2671, out_b=0; a=0, b=0 -> 0, 0.
REQ-033 GS a=100, b=200, w=767 -> out_a=300, out_b=3229.
REQ-034 2L back-to-back CT samples -> in_ready stays 1, 2L consecutive out_valid pulses, in order, busy drops 1 cycle after the last.
REQ-035 CT burst then GS sample presented while busy -> in_ready=0 until the counter reaches 0; GS accepted exactly one cycle after IDLE, result correct.
REQ-036 rst pulse with 3 samples in flight -> outputs 0 immediately, no out_valid for those samples, next accepted sample correct after L cycles.
